// File: rtl/vacc_pingpong.sv
// Double-buffered vector accumulator: one RAM bank integrates while the other drains over valid/ready.
// Define VACC_SATURATE_EN to clamp the accumulator at full scale instead of wrapping.
module vacc_pingpong #(
  parameter int VECTOR_WIDTH = 11,
  parameter int INPUT_WIDTH  = 36,
  parameter int OUTPUT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    sync,
  input  logic                    trig,
  input  logic [31:0]             acc_n,
  output logic [OUTPUT_WIDTH-1:0] m_tdata,
  output logic [VECTOR_WIDTH-1:0] m_addr,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    overflow,
  input  logic                    clr_overflow,
  output logic [15:0]             dump_count
);

  localparam int NCH = 2 ** VECTOR_WIDTH;
  localparam logic [VECTOR_WIDTH-1:0] CH_MAX = '1;

  typedef enum logic [1:0] {WAIT_SYNC, WAIT_TRIG, WAIT_START, ACCUM} state_t;

  function automatic logic [OUTPUT_WIDTH-1:0] sat_add(input logic [OUTPUT_WIDTH-1:0] a,
                                                     input logic [OUTPUT_WIDTH-1:0] b);
    logic [OUTPUT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef VACC_SATURATE_EN
    return s[OUTPUT_WIDTH] ? {OUTPUT_WIDTH{1'b1}} : s[OUTPUT_WIDTH-1:0];
`else
    return s[OUTPUT_WIDTH-1:0];
`endif
  endfunction

  state_t state, state_nxt;
  logic [VECTOR_WIDTH-1:0] chan;
  logic [31:0] pass_cnt, acc_lat, acc_eff;
  logic        active;
  logic        in_fire, pass_last;

  logic [OUTPUT_WIDTH-1:0] mem [0:2*NCH-1];

  logic                    vld_p0, first_p0, done_p0;
  logic [OUTPUT_WIDTH-1:0] data_p0, acc_p0;
  logic [VECTOR_WIDTH-1:0] addr_p0;
  logic                    vld_p1, done_p1;
  logic [OUTPUT_WIDTH-1:0] sum_p1;
  logic [VECTOR_WIDTH-1:0] addr_p1;
  logic                    complete;

  logic                    dr_busy, rd_pend, rd_vld, issue, pop, push, rd_last;
  logic [VECTOR_WIDTH-1:0] rd_addr, rd_idx;
  logic [OUTPUT_WIDTH-1:0] rd_data;
  logic [1:0]              fifo_cnt, occ;
  logic [OUTPUT_WIDTH-1:0] sk_data;
  logic [VECTOR_WIDTH-1:0] sk_addr;
  logic                    sk_last;

  assign acc_eff   = (acc_n == 32'd0) ? 32'd1 : acc_n;
  assign in_fire   = ce && (state == ACCUM);
  assign pass_last = (pass_cnt == acc_lat - 32'd1);
  assign complete  = vld_p1 && done_p1;

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_SYNC:  if (ce && sync) state_nxt = WAIT_TRIG;
      WAIT_TRIG:  if (trig) state_nxt = WAIT_START;
      WAIT_START: if (ce && chan == CH_MAX) state_nxt = ACCUM;
      ACCUM:      state_nxt = ACCUM;
      default:    state_nxt = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_SYNC;
      chan     <= '0;
      pass_cnt <= '0;
      acc_lat  <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= in_fire;
      vld_p1 <= vld_p0;
      if (ce && (state != WAIT_SYNC || sync)) chan <= chan + VECTOR_WIDTH'(1);
      if (in_fire && chan == '0 && pass_cnt == '0) acc_lat <= acc_eff;
      if (in_fire && chan == CH_MAX) pass_cnt <= pass_last ? 32'd0 : pass_cnt + 32'd1;
    end
  end

  // Stage 0: capture sample and read the running sum of this channel
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p0  <= OUTPUT_WIDTH'(data_in);
      addr_p0  <= chan;
      first_p0 <= (pass_cnt == '0);
      done_p0  <= (chan == CH_MAX) && pass_last;
      acc_p0   <= mem[{active, chan}];
    end
  end

  // Stage 1: add, or overwrite on the first pass so no bank clear is needed
  always_ff @(posedge clk) begin
    sum_p1  <= first_p0 ? data_p0 : sat_add(acc_p0, data_p0);
    addr_p1 <= addr_p0;
    done_p1 <= done_p0;
  end

  // Stage 2: write back; the drain port reads the opposite bank
  always_ff @(posedge clk) begin
    if (vld_p1) mem[{active, addr_p1}] <= sum_p1;
    if (issue) begin
      rd_data <= mem[{~active, rd_addr}];
      rd_idx  <= rd_addr;
    end
  end

  assign pop     = m_tvalid && m_tready;
  assign push    = rd_vld;
  assign rd_last = (rd_idx == CH_MAX);
  assign occ     = fifo_cnt + {1'b0, rd_vld};
  // Reads in flight plus buffered words never exceed the two skid slots
  assign issue   = rd_pend && (occ < 2'd2 || pop);
  assign m_tvalid = (fifo_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      dump_count <= '0;
      overflow   <= 1'b0;
      dr_busy    <= 1'b0;
      rd_pend    <= 1'b0;
      rd_addr    <= '0;
      rd_vld     <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_addr <= rd_addr + VECTOR_WIDTH'(1);
        if (rd_addr == CH_MAX) rd_pend <= 1'b0;
      end
      if (pop && m_tlast) dr_busy <= 1'b0;
      if (complete && !dr_busy) begin
        active     <= ~active;
        dump_count <= dump_count + 16'd1;
        dr_busy    <= 1'b1;
        rd_pend    <= 1'b1;
        rd_addr    <= '0;
      end
      if (complete && dr_busy) overflow <= 1'b1;
      else if (clr_overflow)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt <= '0;
      m_tdata  <= '0;
      m_addr   <= '0;
      m_tlast  <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            m_tdata <= rd_data;
            m_addr  <= rd_idx;
            m_tlast <= rd_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          m_tdata  <= sk_data;
          m_addr   <= sk_addr;
          m_tlast  <= sk_last;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            m_tdata <= rd_data;
            m_addr  <= rd_idx;
            m_tlast <= rd_last;
          end else begin
            m_tdata <= sk_data;
            m_addr  <= sk_addr;
            m_tlast <= sk_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && ((fifo_cnt == 2'd1 && !pop) || (fifo_cnt == 2'd2 && pop))) begin
      sk_data <= rd_data;
      sk_addr <= rd_idx;
      sk_last <= rd_last;
    end
  end

endmodule

// File: tb/tb_vacc_pingpong.sv
// Randomized bench for vacc_pingpong: integrations are modelled as per-channel sums of driven spectra.
module tb_vacc_pingpong;
  localparam int VW   = 3;
  localparam int IW   = 8;
  localparam int OW   = 8;
  localparam int NCH  = 8;
  localparam int MAXV = 2 ** OW - 1;
`ifdef VACC_SATURATE_EN
  localparam int T5_EXP = 255;
`else
  localparam int T5_EXP = 144;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, sync = 1'b0, trig = 1'b0;
  logic m_tready = 1'b0, clr_overflow = 1'b0;
  logic [IW-1:0] data_in = '0;
  logic [31:0]   acc_n = 32'd1;
  logic [OW-1:0] m_tdata;
  logic [VW-1:0] m_addr;
  logic          m_tvalid, m_tlast, overflow;
  logic [15:0]   dump_count;

  vacc_pingpong #(.VECTOR_WIDTH(VW), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .data_in(data_in), .sync(sync), .trig(trig),
    .acc_n(acc_n), .m_tdata(m_tdata), .m_addr(m_addr), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .overflow(overflow),
    .clr_overflow(clr_overflow), .dump_count(dump_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0, n_errors = 0;
  int ref_acc [NCH];
  int spec [NCH];
  int ref_pass = 0, ref_n = 1, ref_dumps = 0;
  bit ref_drop = 0;
  int exp_data [0:511];
  int exp_addr [0:511];
  int wr_idx = 0, rd_idx = 0;
  int ready_mode = 0, stall_run = 0, last_beat = 0;
  bit prev_stall = 0;
  logic [OW-1:0] held_d;
  logic [VW-1:0] held_a;
  logic          held_l;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_add(input int a, input int b);
`ifdef VACC_SATURATE_EN
    return (a + b > MAXV) ? MAXV : a + b;
`else
    return (a + b) % (MAXV + 1);
`endif
  endfunction

  task automatic model_spectrum();
    if (ref_pass == 0) ref_n = (acc_n == 0) ? 1 : int'(acc_n);
    for (int c = 0; c < NCH; c++)
      ref_acc[c] = (ref_pass == 0) ? spec[c] : ref_add(ref_acc[c], spec[c]);
    ref_pass++;
    if (ref_pass == ref_n) begin
      ref_pass = 0;
      if (ref_drop) ref_drop = 0;
      else begin
        for (int c = 0; c < NCH; c++) begin
          exp_data[wr_idx] = ref_acc[c];
          exp_addr[wr_idx] = c;
          wr_idx++;
        end
        ref_dumps++;
      end
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      rd_idx = wr_idx;
      prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      check("stall_data", m_tdata, held_d);
      check("stall_addr", m_addr, held_a);
      check("stall_last", m_tlast, held_l);
    end
    if (m_tvalid && m_tready) begin
      check("beat_expected", rd_idx < wr_idx, 1);
      if (rd_idx < wr_idx) begin
        check("beat_data", m_tdata, exp_data[rd_idx]);
        check("beat_addr", m_addr, exp_addr[rd_idx]);
        check("beat_last", m_tlast, exp_addr[rd_idx] == NCH - 1);
        rd_idx++;
      end
      last_beat = m_tdata;
    end
    prev_stall = m_tvalid && !m_tready;
    held_d = m_tdata;
    held_a = m_addr;
    held_l = m_tlast;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_tready = 1'b0;
      1: m_tready = 1'b1;
      default: m_tready = (stall_run >= 3) ? 1'b1 : 1'($urandom % 2);
    endcase
    stall_run = m_tready ? 0 : stall_run + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic spectrum(input int pat, input bit gaps, input bit warm);
    int d;
    for (int c = 0; c < NCH; c++) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin
        ce = 1'b0;
        step();
      end
      case (pat)
        0: d = c + 1;
        1: d = 1;
        2: d = int'($urandom_range(0, 255));
        3: d = 200;
        default: d = (c * 3 + 7) % 256;
      endcase
      ce = 1'b1;
      sync = warm && (c == 0);
      trig = warm && (c == 1);
      data_in = IW'(d);
      spec[c] = d;
      step();
    end
    ce = 1'b0;
    sync = 1'b0;
    trig = 1'b0;
    if (!warm) model_spectrum();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (rd_idx != wr_idx && k < budget) begin
      step();
      k++;
    end
    check(tag, rd_idx, wr_idx);
    idle(3);
  endtask

  initial begin
    idle(3);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_addr", m_addr, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dumps", dump_count, 0);
    rst_n = 1'b1;
    ready_mode = 1;
    idle(2);

    // Basic ramp, four spectra per dump
    acc_n = 32'd4;
    spectrum(0, 0, 1);
    repeat (4) spectrum(0, 0, 0);
    wait_drain("t1_drained", 40);
    check("t1_dumps", dump_count, ref_dumps);
    check("t1_overflow", overflow, 0);

    // Back-to-back integrations with no ce gap
    acc_n = 32'd2;
    repeat (6) spectrum(1, 0, 0);
    wait_drain("t2_drained", 40);
    check("t2_dumps", dump_count, ref_dumps);
    check("t2_overflow", overflow, 0);

    // Random data, ce gaps and random backpressure
    ready_mode = 2;
    acc_n = 32'd6;
    repeat (12) spectrum(2, 1, 0);
    wait_drain("t4_drained", 200);
    ready_mode = 1;
    check("t4_dumps", dump_count, ref_dumps);
    check("t4_overflow", overflow, 0);

    // Wrap or clamp at full scale
    acc_n = 32'd2;
    repeat (2) spectrum(3, 0, 0);
    wait_drain("t5_drained", 40);
    check("t5_value", last_beat, T5_EXP);
    check("t5_dumps", dump_count, ref_dumps);

    // Held drain across the next completion
    acc_n = 32'd1;
    ready_mode = 0;
    spectrum(4, 0, 0);
    idle(4);
    check("t3_tvalid", m_tvalid, 1);
    check("t3_head", m_tdata, exp_data[rd_idx]);
    ref_drop = 1;
    spectrum(2, 0, 0);
    idle(4);
    check("t3_overflow", overflow, 1);
    check("t3_dumps", dump_count, ref_dumps);
    check("t3_head_held", m_tdata, exp_data[rd_idx]);
    check("t3_addr_held", m_addr, 0);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    step();
    check("t3_clr", overflow, 0);
    ready_mode = 1;
    wait_drain("t3_drained", 40);

    // Reset in the middle of a drain
    ready_mode = 0;
    spectrum(2, 0, 0);
    idle(4);
    check("t6_pre_tvalid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", m_tvalid, 0);
    check("t6_rst_tdata", m_tdata, 0);
    check("t6_rst_dumps", dump_count, 0);
    check("t6_rst_overflow", overflow, 0);
    ref_pass = 0;
    ref_drop = 0;
    ref_dumps = 0;
    idle(3);
    rst_n = 1'b1;
    ready_mode = 1;
    idle(2);
    acc_n = 32'd3;
    spectrum(2, 0, 1);
    repeat (3) spectrum(2, 0, 0);
    wait_drain("t6_drained", 40);
    check("t6_dumps", dump_count, ref_dumps);
    check("t6_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
